rx: RTL and testbench

//   UART receiver, the counterpart of the team's tx block: 1 start bit, 8 data

---
 rtl/rx_pkg.sv | 16 +
 rtl/rx.sv | 122 ++++++++++++
 tb/tb_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared UART constants and the receiver state type; tx may import the same values.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ACK
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic PARITY_ODD = 1'b1;

endpackage

// File: rtl/rx.sv
// UART receiver: 1 start, 8 data LSB first, odd parity, 1 stop. Samples mid-bit
// and holds the byte on Dout with Receive high until the consumer acknowledges.
module rx
  import rx_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic       Receive,
  output logic [7:0] Dout,
  output logic       parityErr,
  output logic       frameErr,
  output logic       busy
);

  localparam int BAUD_PERIOD = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_PERIOD = BAUD_PERIOD / 2;
  localparam int TW          = $clog2(BAUD_PERIOD);

  localparam logic [TW-1:0] BIT_END  = TW'(BAUD_PERIOD - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_PERIOD - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t     state;
  logic          sin_meta, sin_s;
  logic [TW-1:0] timer;
  logic [2:0]    bit_num;
  logic [7:0]    shift;
  logic          par_bit;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      sin_meta  <= 1'b1;
      sin_s     <= 1'b1;
      timer     <= '0;
      bit_num   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      Receive   <= 1'b0;
      Dout      <= '0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sin_meta <= Sin;
      sin_s    <= sin_meta;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!sin_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_END) begin
            timer <= '0;
            if (!sin_s) begin
              state <= DATA;
            end else begin
              // line went back high before mid-start: treat as a glitch
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_END) begin
            timer   <= '0;
            shift   <= {sin_s, shift[7:1]};
            bit_num <= bit_num + 1'b1;
            if (bit_num == LAST_BIT) state <= PARITY;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PARITY: begin
          if (timer == BIT_END) begin
            timer   <= '0;
            par_bit <= sin_s;
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == BIT_END) begin
            timer     <= '0;
            Dout      <= shift;
            frameErr  <= ~sin_s;
            parityErr <= (^{shift, par_bit}) ^ PARITY_ODD;
            Receive   <= 1'b1;
            busy      <= 1'b0;
            state     <= ACK;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ACK: begin
          timer <= '0;
          if (ReceiveAck) begin
            Receive <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: drives bit-accurate frames on Sin and compares
// the delivered byte and flags against a frame-level reference model.
module tb_rx;

  localparam int CLK_FREQUENCY = 3_200_000;
  localparam int BAUD_RATE     = 100_000;
  localparam int BP            = CLK_FREQUENCY / BAUD_RATE;
  localparam int HP            = BP / 2;
  // start edge -> stop-bit midpoint (half + 10 bits) plus synchronizer/IDLE hop
  localparam int LAT           = HP + 10 * BP + 3;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Sin = 1'b1;
  logic       ReceiveAck = 1'b0;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;
  logic       frameErr;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  rx #(.CLK_FREQUENCY(CLK_FREQUENCY), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .Reset(Reset), .Sin(Sin), .ReceiveAck(ReceiveAck),
    .Receive(Receive), .Dout(Dout), .parityErr(parityErr),
    .frameErr(frameErr), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference: {parityErr, frameErr, data} for a frame sent with given parity/stop bits
  function automatic logic [9:0] ref_frame(input logic [7:0] d, input logic par, input logic stop);
    logic perr;
    perr = (($countones({d, par}) % 2) == 0);
    return {perr, ~stop, d};
  endfunction

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      Sin = bits[i];
      repeat (BP) @(posedge clk);
      #1;
    end
    Sin = 1'b1;
  endtask

  task automatic wait_receive(input int limit, output int cycles, output bit got, output bit saw_busy);
    cycles = 0; got = 0; saw_busy = 0;
    while (cycles < limit && !got) begin
      @(negedge clk);
      cycles++;
      if (busy) saw_busy = 1;
      if (Receive) got = 1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (Receive !== 1'b0) begin n_bad++; $display("FAIL reset_receive got %b want 0", Receive); end
    n_cmp++; if (Dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h want 00", Dout); end
    n_cmp++; if ({parityErr, frameErr} !== 2'b00) begin n_bad++; $display("FAIL reset_errs got %b want 00", {parityErr, frameErr}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  // send one frame, check delivery, hold behaviour and acknowledge
  task automatic test_frame(input string name, input logic [7:0] d, input logic par, input logic stop);
    logic [9:0] exp;
    int         cyc;
    bit         got, sb;
    exp = ref_frame(d, par, stop);
    fork
      drive_frame(d, par, stop);
      wait_receive(LAT + 50, cyc, got, sb);
    join
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL %s_timeout no Receive within %0d clks", name, LAT + 50);
    end else begin
      n_cmp++; if (cyc < LAT - 1 || cyc > LAT + 1) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", name, cyc, LAT); end
      n_cmp++; if (sb !== 1'b1) begin n_bad++; $display("FAIL %s_busy never seen during frame", name); end
    end
    n_cmp++; if (Dout !== exp[7:0]) begin n_bad++; $display("FAIL %s_dout got %h want %h", name, Dout, exp[7:0]); end
    n_cmp++; if ({parityErr, frameErr} !== exp[9:8]) begin n_bad++; $display("FAIL %s_errs got %b want %b", name, {parityErr, frameErr}, exp[9:8]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_ack got %b want 0", name, busy); end
    repeat (5) @(negedge clk);
    n_cmp++; if ({Receive, Dout} !== {1'b1, exp[7:0]}) begin n_bad++; $display("FAIL %s_hold got %b/%h want 1/%h", name, Receive, Dout, exp[7:0]); end
    @(posedge clk); #1 ReceiveAck = 1'b1;
    @(posedge clk); #1 ReceiveAck = 1'b0;
    @(negedge clk);
    n_cmp++; if (Receive !== 1'b0) begin n_bad++; $display("FAIL %s_ack got %b want 0", name, Receive); end
    n_cmp++; if (Dout !== exp[7:0]) begin n_bad++; $display("FAIL %s_dout_after_ack got %h want %h", name, Dout, exp[7:0]); end
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_glitch();
    logic [7:0] prev;
    prev = Dout;
    Sin = 1'b0;
    repeat (HP / 2) @(posedge clk);
    #1 Sin = 1'b1;
    repeat (2 * BP) @(negedge clk);
    n_cmp++; if (Receive !== 1'b0) begin n_bad++; $display("FAIL glitch_receive got %b want 0", Receive); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy got %b want 0", busy); end
    n_cmp++; if (Dout !== prev) begin n_bad++; $display("FAIL glitch_dout got %h want %h", Dout, prev); end
    @(posedge clk); #1;
    test_frame("glitch_next", 8'h5A, odd_par(8'h5A), 1'b1);
  endtask

  task automatic test_reset_mid();
    fork
      drive_frame(8'hFF, odd_par(8'hFF), 1'b1);
      begin
        repeat (5 * BP + BP / 2) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;
        @(negedge clk);
        n_cmp++; if ({Receive, Dout, parityErr, frameErr, busy} !== 12'h000) begin
          n_bad++; $display("FAIL midreset_outputs got R=%b D=%h p=%b f=%b b=%b want all 0", Receive, Dout, parityErr, frameErr, busy);
        end
      end
    join
    repeat (BP) @(negedge clk);
    n_cmp++; if ({Receive, busy} !== 2'b00) begin n_bad++; $display("FAIL midreset_quiet got %b want 00", {Receive, busy}); end
    @(posedge clk); #1;
    test_frame("midreset_next", 8'h81, odd_par(8'h81), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen[$];
    int         high_cycles;
    bit         any_err;
    high_cycles = 0; any_err = 0;
    ReceiveAck = 1'b1;
    fork
      begin
        drive_frame(8'h01, odd_par(8'h01), 1'b1);
        drive_frame(8'h80, odd_par(8'h80), 1'b1);
      end
      for (int i = 0; i < 22 * BP + 20; i++) begin
        @(negedge clk);
        if (Receive) begin
          high_cycles++;
          seen.push_back(Dout);
          if (parityErr || frameErr) any_err = 1;
        end
      end
    join
    ReceiveAck = 1'b0;
    n_cmp++; if (high_cycles !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", high_cycles); end
    n_cmp++; if (seen.size() < 1 || seen[0] !== 8'h01) begin n_bad++; $display("FAIL b2b_first got %h want 01", seen.size() > 0 ? seen[0] : 8'hxx); end
    n_cmp++; if (seen.size() < 2 || seen[1] !== 8'h80) begin n_bad++; $display("FAIL b2b_second got %h want 80", seen.size() > 1 ? seen[1] : 8'hxx); end
    n_cmp++; if (any_err !== 1'b0) begin n_bad++; $display("FAIL b2b_errs got %b want 0", any_err); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p, s;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      p = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      test_frame($sformatf("rand%0d", i), d, p, s);
    end
  endtask

  initial begin
    test_reset();
    test_frame("a5", 8'hA5, 1'b1, 1'b1);
    test_frame("par_err", 8'h00, 1'b0, 1'b1);
    test_frame("frame_err", 8'h3C, 1'b1, 1'b0);
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
